// File: rtl/wb_axil_pkg.sv
// Shared types and AXI4-Lite constants for the Wishbone -> AXI4-Lite bridge.
package wb_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,  // waiting for a Wishbone request
    WR,    // AW and/or W still pending
    WB,    // waiting for the write response
    RD,    // AR pending
    RR     // waiting for read data
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // EXOKAY is folded into OKAY; only SLVERR/DECERR report an error upstream.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/wb_axil_bridge_if.sv
// Wishbone pipelined slave port plus AXI4-Lite master channels of the bridge.
// slave modport: the bridge itself. master modport: the surrounding system.
interface wb_axil_bridge_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WB_ADDR_W = 32
) ();

  // Wishbone side
  logic                   wb_cyc;
  logic                   wb_stb;
  logic                   wb_we;
  logic [WB_ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]      wb_wdata;
  logic [DATA_W/8-1:0]    wb_sel;
  logic                   wb_stall;
  logic                   wb_ack;
  logic                   wb_err;
  logic [DATA_W-1:0]      wb_rdata;

  // AXI4-Lite side
  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_W-1:0]      aw_addr;
  logic [2:0]             aw_prot;
  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_W-1:0]      w_data;
  logic [DATA_W/8-1:0]    w_strb;
  logic                   b_valid;
  logic                   b_ready;
  logic [1:0]             b_resp;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [ADDR_W-1:0]      ar_addr;
  logic [2:0]             ar_prot;
  logic                   r_valid;
  logic                   r_ready;
  logic [DATA_W-1:0]      r_data;
  logic [1:0]             r_resp;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    output wb_stall, wb_ack, wb_err, wb_rdata,
    output aw_valid, aw_addr, aw_prot,
    input  aw_ready,
    output w_valid, w_data, w_strb,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_prot,
    input  ar_ready,
    input  r_valid, r_data, r_resp,
    output r_ready
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel,
    input  wb_stall, wb_ack, wb_err, wb_rdata,
    input  aw_valid, aw_addr, aw_prot,
    output aw_ready,
    input  w_valid, w_data, w_strb,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_prot,
    output ar_ready,
    output r_valid, r_data, r_resp,
    input  r_ready
  );

endinterface

// File: rtl/wb_axil_bridge.sv
// Pipelined Wishbone slave -> AXI4-Lite master bridge, one transaction in flight.
module wb_axil_bridge
  import wb_axil_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned WB_ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_axil_bridge_if.slave bus
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned LsbW  = $clog2(StrbW);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [StrbW-1:0]    strb_q, strb_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                aborted_q, aborted_d;

  logic                abort_now;
  logic                aw_done;
  logic                w_done;

  // Address bits outside the AXI window and below word alignment are dropped.
  logic unused_addr;
  assign unused_addr = ^{bus.wb_addr[WB_ADDR_W-1:ADDR_W], bus.wb_addr[LsbW-1:0]};

  // The initiator has walked away if cyc drops at any point of the transaction.
  assign abort_now = aborted_q | ~bus.wb_cyc;
  assign aw_done   = ~aw_valid_q | bus.aw_ready;
  assign w_done    = ~w_valid_q | bus.w_ready;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state logic: accept, drive AXI handshakes, generate the completion pulse.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    aborted_d  = abort_now;

    unique case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        if (bus.wb_cyc && bus.wb_stb) begin
          addr_d = {bus.wb_addr[ADDR_W-1:LsbW], {LsbW{1'b0}}};
          data_d = bus.wb_wdata;
          strb_d = bus.wb_sel;
          if (bus.wb_we) begin
            state_d    = WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        // Each channel retires on its own ready; move on once both have gone.
        if (bus.aw_ready) aw_valid_d = 1'b0;
        if (bus.w_ready)  w_valid_d  = 1'b0;
        if (aw_done && w_done) state_d = WB;
      end
      WB: begin
        if (bus.b_valid) begin
          state_d = IDLE;
          if (!abort_now) begin
            err_d = resp_is_err(bus.b_resp);
            ack_d = ~resp_is_err(bus.b_resp);
          end
        end
      end
      RD: begin
        if (bus.ar_ready) state_d = RR;
      end
      RR: begin
        if (bus.r_valid) begin
          state_d = IDLE;
          if (!abort_now) begin
            rdata_d = bus.r_data;
            err_d   = resp_is_err(bus.r_resp);
            ack_d   = ~resp_is_err(bus.r_resp);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
      end
    endcase
  end

  assign bus.wb_stall = (state_q != IDLE);
  assign bus.wb_ack   = ack_q;
  assign bus.wb_err   = err_q;
  assign bus.wb_rdata = rdata_q;

  assign bus.aw_valid = aw_valid_q;
  assign bus.aw_addr  = addr_q;
  assign bus.aw_prot  = AXI_PROT_DEFAULT;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = data_q;
  assign bus.w_strb   = strb_q;
  assign bus.b_ready  = (state_q == WB);
  assign bus.ar_valid = (state_q == RD);
  assign bus.ar_addr  = addr_q;
  assign bus.ar_prot  = AXI_PROT_DEFAULT;
  assign bus.r_ready  = (state_q == RR);

endmodule

// File: tb/tb_wb_axil_bridge.sv
// Directed bench for wb_axil_bridge with a small configurable AXI-Lite slave model.
module tb_wb_axil_bridge;

  logic clk;
  logic rst;

  wb_axil_bridge_if #(.DATA_W(32), .ADDR_W(16), .WB_ADDR_W(32)) bus ();

  wb_axil_bridge #(.DATA_W(32), .ADDR_W(16), .WB_ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Slave model configuration (ready delays in cycles after valid rises).
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  assign bus.aw_ready = bus.aw_valid && (aw_cnt >= aw_dly);
  assign bus.w_ready  = bus.w_valid && (w_cnt >= w_dly);
  assign bus.ar_ready = bus.ar_valid && (ar_cnt >= ar_dly);
  assign bus.b_valid  = bus.b_ready;
  assign bus.b_resp   = b_resp_cfg;
  assign bus.r_valid  = bus.r_ready && (r_cnt >= r_dly);
  assign bus.r_data   = r_data_cfg;
  assign bus.r_resp   = r_resp_cfg;

  // Event counters and captured handshake payloads.
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_ack = 0, n_err = 0;
  int aw_hi = 0, w_hi = 0, proto_bad = 0, aw_unstable = 0;
  logic [15:0] cap_awaddr = '0, cap_araddr = '0, prev_awaddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        aw_pend_prev = 1'b0;

  always @(posedge clk) begin
    aw_cnt <= (bus.aw_valid && !bus.aw_ready) ? aw_cnt + 1 : 0;
    w_cnt  <= (bus.w_valid && !bus.w_ready) ? w_cnt + 1 : 0;
    ar_cnt <= (bus.ar_valid && !bus.ar_ready) ? ar_cnt + 1 : 0;
    r_cnt  <= (bus.r_ready && !bus.r_valid) ? r_cnt + 1 : 0;
    if (bus.aw_valid && bus.aw_ready) begin n_aw <= n_aw + 1; cap_awaddr <= bus.aw_addr; end
    if (bus.w_valid && bus.w_ready) begin
      n_w <= n_w + 1; cap_wdata <= bus.w_data; cap_wstrb <= bus.w_strb;
    end
    if (bus.b_valid && bus.b_ready) n_b <= n_b + 1;
    if (bus.ar_valid && bus.ar_ready) begin n_ar <= n_ar + 1; cap_araddr <= bus.ar_addr; end
    if (bus.r_valid && bus.r_ready) n_r <= n_r + 1;
    if (bus.wb_ack) n_ack <= n_ack + 1;
    if (bus.wb_err) n_err <= n_err + 1;
    if (bus.aw_valid) aw_hi <= aw_hi + 1;
    if (bus.w_valid) w_hi <= w_hi + 1;
    if (bus.b_ready && (bus.aw_valid || bus.w_valid)) proto_bad <= proto_bad + 1;
    if (aw_pend_prev && (!bus.aw_valid || bus.aw_addr != prev_awaddr))
      aw_unstable <= aw_unstable + 1;
    aw_pend_prev <= bus.aw_valid && !bus.aw_ready;
    prev_awaddr  <= bus.aw_addr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request from a negedge; returns just after the accepting posedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_addr  = addr;
    bus.wb_wdata = data;
    bus.wb_sel   = sel;
    @(posedge clk);
    #1 bus.wb_stb = 1'b0;
  endtask

  // Cycles counted from the accept cycle; returns at the negedge of the ack/err cycle.
  task automatic wait_done(output int lat, output logic ack, output logic err,
                           output logic stall1);
    logic done;
    done = 1'b0; lat = -1; ack = 1'b0; err = 1'b0; stall1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (i == 1) stall1 = bus.wb_stall;
        if (bus.wb_ack || bus.wb_err) begin
          done = 1'b1; lat = i; ack = bus.wb_ack; err = bus.wb_err;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int   lat;
  logic ack, err, st1;
  int   s_aw, s_w, s_b, s_ar, s_r, s_ack, s_err, s_awhi, s_whi, s_pb, s_un;

  task automatic snap();
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_ack = n_ack; s_err = n_err;
    s_awhi = aw_hi; s_whi = w_hi; s_pb = proto_bad; s_un = aw_unstable;
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_addr = '0; bus.wb_wdata = '0; bus.wb_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ctrl", 32'({bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready,
                               bus.r_ready, bus.wb_ack, bus.wb_err, bus.wb_stall}), 32'h0);
    check_eq("reset_rdata", bus.wb_rdata, 32'h0);
    rst = 1'b0;
    idle_cycles(1);

    // Plain write, slave responds immediately.
    snap();
    issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
    wait_done(lat, ack, err, st1);
    check_eq("wr_lat", 32'(lat), 32'd3);
    check_eq("wr_ack", 32'({ack, err}), 32'b10);
    check_eq("wr_stall", 32'(st1), 32'd1);
    check_eq("wr_awaddr", 32'(cap_awaddr), 32'h0104);
    check_eq("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    check_eq("wr_wstrb", 32'(cap_wstrb), 32'hF);
    idle_cycles(2);
    check_eq("wr_counts", 32'({8'(n_aw - s_aw), 8'(n_b - s_b), 8'(n_ack - s_ack)}),
             32'h01_0101);

    // Write with awready held off 4 cycles: wvalid retires first, awvalid stays stable.
    snap();
    aw_dly = 4;
    issue(1'b1, 32'h0000_0200, 32'h0000_5555, 4'h3);
    wait_done(lat, ack, err, st1);
    aw_dly = 0;
    check_eq("wrd_lat", 32'(lat), 32'd7);
    check_eq("wrd_aw_hi", 32'(aw_hi - s_awhi), 32'd5);
    check_eq("wrd_w_hi", 32'(w_hi - s_whi), 32'd1);
    check_eq("wrd_bready_early", 32'(proto_bad - s_pb), 32'd0);
    check_eq("wrd_aw_stable", 32'(aw_unstable - s_un), 32'd0);
    idle_cycles(2);
    check_eq("wrd_one_ack", 32'(n_ack - s_ack), 32'd1);

    // Read returning SLVERR: error pulse, data still captured.
    snap();
    r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b10;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    wait_done(lat, ack, err, st1);
    check_eq("rderr_lat", 32'(lat), 32'd3);
    check_eq("rderr_flags", 32'({ack, err}), 32'b01);
    check_eq("rderr_araddr", 32'(cap_araddr), 32'h0010);
    check_eq("rderr_data", bus.wb_rdata, 32'h1234_5678);
    idle_cycles(2);
    check_eq("rderr_counts", 32'({8'(n_err - s_err), 8'(n_ack - s_ack)}), 32'h0100);

    // EXOKAY read with out-of-window, unaligned address.
    r_data_cfg = 32'hA5A5_0F0F; r_resp_cfg = 2'b01;
    issue(1'b0, 32'h0001_0107, 32'h0, 4'hF);
    wait_done(lat, ack, err, st1);
    check_eq("exok_flags", 32'({ack, err}), 32'b10);
    check_eq("exok_araddr", 32'(cap_araddr), 32'h0104);
    check_eq("exok_data", bus.wb_rdata, 32'hA5A5_0F0F);

    // Back-to-back: write with sel=0 presented in the read's ack cycle.
    r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = 2'b00;
    issue(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_done(lat, ack, err, st1);
    check_eq("b2b_rd_ack", 32'({ack, err}), 32'b10);
    check_eq("b2b_stall_on_ack", 32'(bus.wb_stall), 32'd0);
    issue(1'b1, 32'h0000_0030, 32'h1122_3344, 4'h0);
    wait_done(lat, ack, err, st1);
    check_eq("b2b_wr_lat", 32'(lat), 32'd3);
    check_eq("b2b_wr_stall", 32'(st1), 32'd1);
    check_eq("b2b_wr_ack", 32'({ack, err}), 32'b10);
    check_eq("b2b_wstrb", 32'(cap_wstrb), 32'h0);
    check_eq("b2b_awaddr", 32'(cap_awaddr), 32'h0030);
    check_eq("b2b_rdata_kept", bus.wb_rdata, 32'h0BAD_F00D);

    // Abort while waiting for R: handshake completes, nothing reported upstream.
    idle_cycles(1);
    snap();
    r_dly = 3; r_data_cfg = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    idle_cycles(2);
    check_eq("abort_in_rr", 32'(bus.r_ready), 32'd1);
    bus.wb_cyc = 1'b0;
    for (int i = 0; i < 20; i++) if (n_r == s_r) @(negedge clk);
    idle_cycles(3);
    r_dly = 0;
    check_eq("abort_r_hs", 32'(n_r - s_r), 32'd1);
    check_eq("abort_no_resp", 32'({8'(n_ack - s_ack), 8'(n_err - s_err)}), 32'h0);
    check_eq("abort_rdata", bus.wb_rdata, 32'h0BAD_F00D);
    check_eq("abort_idle", 32'(bus.wb_stall), 32'd0);
    r_data_cfg = 32'h00C0_FFEE;
    issue(1'b0, 32'h0000_0044, 32'h0, 4'hF);
    wait_done(lat, ack, err, st1);
    check_eq("post_abort_lat", 32'(lat), 32'd3);
    check_eq("post_abort_ack", 32'({ack, err}), 32'b10);
    check_eq("post_abort_data", bus.wb_rdata, 32'h00C0_FFEE);

    // stb without cyc in IDLE is ignored.
    idle_cycles(1);
    snap();
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
    idle_cycles(2);
    check_eq("nocyc_stall", 32'(bus.wb_stall), 32'd0);
    bus.wb_stb = 1'b0;
    idle_cycles(1);
    check_eq("nocyc_no_axi", 32'({8'(n_aw - s_aw), 8'(n_ar - s_ar)}), 32'h0);

    // Reset while in WR drops valids and emits nothing.
    snap();
    aw_dly = 10; w_dly = 10;
    issue(1'b1, 32'h0000_0080, 32'h7777_7777, 4'hF);
    @(negedge clk);
    check_eq("rstwr_pending", 32'({bus.aw_valid, bus.w_valid}), 32'b11);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstwr_valids", 32'({bus.aw_valid, bus.w_valid, bus.wb_stall}), 32'b000);
    rst = 1'b0; bus.wb_cyc = 1'b0;
    idle_cycles(5);
    aw_dly = 0; w_dly = 0;
    check_eq("rstwr_no_resp", 32'({8'(n_ack - s_ack), 8'(n_err - s_err)}), 32'h0);
    check_eq("rstwr_rdata", bus.wb_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
